// File: rtl/cam_alloc_if.sv
// cam_alloc_if: insert/invalidate/flush and multi-port search signals for cam_alloc.
interface cam_alloc_if #(
   parameter int DATA  = 16,
   parameter int DEPTH = 32,
   parameter int READ  = 2
);
   localparam int ADDR = $clog2(DEPTH);
   logic                      ins_;
   logic [DATA-1:0]           ins_d;
   logic [ADDR-1:0]           ins_addr;
   logic                      full;
   logic                      empty;
   logic [ADDR:0]             count;
   logic                      ovf;
   logic                      inv_;
   logic [ADDR-1:0]           inv_addr;
   logic                      flush_;
   logic [READ-1:0]           re_;
   logic [READ-1:0][DATA-1:0] rm;
   logic [READ-1:0][DATA-1:0] rd;
   logic [READ-1:0]           match;
   logic [READ-1:0]           multi;
   logic [READ-1:0][ADDR-1:0] raddr;
   modport master (
      output ins_, ins_d, inv_, inv_addr, flush_, re_, rm, rd,
      input  ins_addr, full, empty, count, ovf, match, multi, raddr
   );
   modport slave (
      input  ins_, ins_d, inv_, inv_addr, flush_, re_, rm, rd,
      output ins_addr, full, empty, count, ovf, match, multi, raddr
   );
endinterface

// File: rtl/cam_alloc.sv
// cam_alloc: masked-search CAM that allocates inserts to the lowest free entry.
module cam_alloc #(
   parameter int DATA    = 16,
   parameter int DEPTH   = 32,
   parameter int READ    = 2,
   parameter int OUT_REG = 0
) (
   input logic       clk,
   input logic       reset_,
   cam_alloc_if.slave bus
);
   localparam int ADDR = $clog2(DEPTH);
   logic [DEPTH-1:0]          valid_q, valid_d;
   logic [DATA-1:0]           cell_q [DEPTH];
   logic [DATA-1:0]           cell_d [DEPTH];
   logic [ADDR:0]             count_q, count_d;
   logic                      ovf_q, ovf_d;
   logic [READ-1:0]           match_q, match_d, multi_q, multi_d;
   logic [READ-1:0][ADDR-1:0] raddr_q, raddr_d;
   logic [READ-1:0][DEPTH-1:0] hit;
   logic [ADDR-1:0]           free;
   logic                      full, ins_ok, inv_ok;
   always_comb begin
      free = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid_q[i]) free = ADDR'(i);
      full    = &valid_q;
      ins_ok  = !bus.ins_ && !full && bus.flush_;
      inv_ok  = !bus.inv_ && valid_q[bus.inv_addr] && bus.flush_;
      valid_d = valid_q;
      cell_d  = cell_q;
      if (inv_ok) valid_d[bus.inv_addr] = 1'b0;
      // insert applied after invalidate so it wins on a shared entry
      if (ins_ok) begin
         valid_d[free] = 1'b1;
         cell_d[free]  = bus.ins_d;
      end
      if (!bus.flush_) valid_d = '0;
      count_d = !bus.flush_ ? '0 : count_q + (ADDR+1)'(ins_ok) - (ADDR+1)'(inv_ok);
      ovf_d   = !bus.ins_ && full && bus.flush_;
      hit     = '0;
      raddr_d = '0;
      for (int r = 0; r < READ; r++) begin
         for (int i = 0; i < DEPTH; i++)
            hit[r][i] = valid_q[i] && !bus.re_[r] && (((cell_q[i] ^ bus.rd[r]) & ~bus.rm[r]) == '0);
         for (int i = DEPTH - 1; i >= 0; i--)
            if (hit[r][i]) raddr_d[r] = ADDR'(i);
         match_d[r] = |hit[r];
         multi_d[r] = |(hit[r] & (hit[r] - DEPTH'(1)));
      end
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         valid_q <= '0;
         cell_q  <= '{default: '0};
         count_q <= '0;
         ovf_q   <= 1'b0;
         match_q <= '0;
         multi_q <= '0;
         raddr_q <= '0;
      end else begin
         valid_q <= valid_d;
         cell_q  <= cell_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         match_q <= match_d;
         multi_q <= multi_d;
         raddr_q <= raddr_d;
      end
   end
   assign bus.ins_addr = free;
   assign bus.full     = full;
   assign bus.empty    = ~|valid_q;
   assign bus.count    = count_q;
   assign bus.ovf      = ovf_q;
   assign bus.match    = OUT_REG != 0 ? match_q : match_d;
   assign bus.multi    = OUT_REG != 0 ? multi_q : multi_d;
   assign bus.raddr    = OUT_REG != 0 ? raddr_q : raddr_d;
endmodule

// File: tb/tb_cam_alloc.sv
// tb_cam_alloc: directed vectors with a queued scoreboard checked at each falling clock edge.
module tb_cam_alloc;
   typedef struct {
      int          d;
      int          s;
      logic [31:0] v;
   } exp_t;
   logic clk = 1'b0;
   logic reset_ = 1'b0;
   int   ncmp = 0;
   int   nbad = 0;
   exp_t q[$];
   exp_t e;
   logic [31:0] act;
   string names [11] = '{"count", "full", "empty", "ins_addr", "ovf",
                         "match0", "multi0", "raddr0", "match1", "multi1", "raddr1"};
   cam_alloc_if #(.DATA(16), .DEPTH(32), .READ(2)) b0 ();
   cam_alloc_if #(.DATA(16), .DEPTH(32), .READ(2)) b1 ();
   cam_alloc #(.DATA(16), .DEPTH(32), .READ(2), .OUT_REG(0)) dut0 (.clk(clk), .reset_(reset_), .bus(b0.slave));
   cam_alloc #(.DATA(16), .DEPTH(32), .READ(2), .OUT_REG(1)) dut1 (.clk(clk), .reset_(reset_), .bus(b1.slave));
   always #5 clk = ~clk;
   function automatic logic [31:0] samp(input int d, input int s);
      case (s)
         0:  return d != 0 ? 32'(b1.count)    : 32'(b0.count);
         1:  return d != 0 ? 32'(b1.full)     : 32'(b0.full);
         2:  return d != 0 ? 32'(b1.empty)    : 32'(b0.empty);
         3:  return d != 0 ? 32'(b1.ins_addr) : 32'(b0.ins_addr);
         4:  return d != 0 ? 32'(b1.ovf)      : 32'(b0.ovf);
         5:  return d != 0 ? 32'(b1.match[0]) : 32'(b0.match[0]);
         6:  return d != 0 ? 32'(b1.multi[0]) : 32'(b0.multi[0]);
         7:  return d != 0 ? 32'(b1.raddr[0]) : 32'(b0.raddr[0]);
         8:  return d != 0 ? 32'(b1.match[1]) : 32'(b0.match[1]);
         9:  return d != 0 ? 32'(b1.multi[1]) : 32'(b0.multi[1]);
         10: return d != 0 ? 32'(b1.raddr[1]) : 32'(b0.raddr[1]);
         default: return '0;
      endcase
   endfunction
   always @(negedge clk) begin
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = samp(e.d, e.s);
         ncmp++;
         if (act !== e.v) begin
            nbad++;
            $display("FAIL dut%0d %s: got 0x%0h want 0x%0h at %0t", e.d, names[e.s], act, e.v, $time);
         end
      end
   end
   task automatic expect_v(input int d, input int s, input logic [31:0] v);
      q.push_back('{d: d, s: s, v: v});
   endtask
   task automatic chk(input int d, input int s, input logic [31:0] v);
      logic [31:0] a;
      a = samp(d, s);
      ncmp++;
      if (a !== v) begin
         nbad++;
         $display("FAIL now dut%0d %s: got 0x%0h want 0x%0h at %0t", d, names[s], a, v, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle0();
      b0.ins_ = 1'b1; b0.ins_d = '0; b0.inv_ = 1'b1; b0.inv_addr = '0;
      b0.flush_ = 1'b1; b0.re_ = '1; b0.rm = '0; b0.rd = '0;
   endtask
   task automatic idle1();
      b1.ins_ = 1'b1; b1.ins_d = '0; b1.inv_ = 1'b1; b1.inv_addr = '0;
      b1.flush_ = 1'b1; b1.re_ = '1; b1.rm = '0; b1.rd = '0;
   endtask
   initial begin
      idle0();
      idle1();
      repeat (2) tick();
      b0.re_ = '0; b0.rm = '1;
      b1.re_ = '0; b1.rm = '1;
      expect_v(0, 0, 0); expect_v(0, 1, 0); expect_v(0, 2, 1); expect_v(0, 3, 0);
      expect_v(0, 4, 0); expect_v(0, 5, 0); expect_v(0, 6, 0); expect_v(0, 7, 0);
      expect_v(0, 8, 0); expect_v(1, 0, 0); expect_v(1, 5, 0); expect_v(1, 7, 0);
      tick();
      idle0();
      idle1();
      reset_ = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         expect_v(0, 3, i);
         expect_v(0, 0, i);
         b0.ins_ = 1'b0;
         b0.ins_d = 16'(16'h100 + i);
         tick();
      end
      expect_v(0, 1, 1); expect_v(0, 0, 32); expect_v(0, 4, 0); expect_v(0, 2, 0);
      b0.ins_ = 1'b0;
      b0.ins_d = 16'h1FF;
      tick();
      b0.ins_ = 1'b1;
      expect_v(0, 4, 1); expect_v(0, 0, 32); expect_v(0, 1, 1);
      tick();
      chk(0, 4, 0);
      b0.re_ = '0;
      b0.rd[0] = 16'h105; b0.rm[0] = 16'h0000;
      b0.rd[1] = 16'h105; b0.rm[1] = 16'h00FF;
      expect_v(0, 5, 1); expect_v(0, 6, 0); expect_v(0, 7, 5);
      expect_v(0, 8, 1); expect_v(0, 9, 1); expect_v(0, 10, 0);
      tick();
      b0.re_ = 2'b10;
      b0.rd[0] = 16'h200;
      expect_v(0, 5, 0); expect_v(0, 7, 0); expect_v(0, 8, 0);
      tick();
      idle0();
      b0.inv_ = 1'b0; b0.inv_addr = 5'd3;
      tick();
      expect_v(0, 0, 31); expect_v(0, 3, 3);
      b0.inv_addr = 5'd7;
      tick();
      b0.inv_ = 1'b1;
      expect_v(0, 0, 30); expect_v(0, 3, 3);
      b0.ins_ = 1'b0; b0.ins_d = 16'hABC;
      tick();
      b0.ins_ = 1'b1;
      expect_v(0, 3, 7); expect_v(0, 0, 31);
      b0.re_ = 2'b10; b0.rd[0] = 16'hABC;
      expect_v(0, 5, 1); expect_v(0, 6, 0); expect_v(0, 7, 3);
      tick();
      b0.re_ = '1;
      b0.inv_ = 1'b0; b0.inv_addr = 5'd7;
      tick();
      expect_v(0, 0, 31);
      b0.inv_addr = 5'd9;
      tick();
      b0.inv_ = 1'b1;
      expect_v(0, 0, 30); expect_v(0, 3, 7);
      b0.ins_ = 1'b0; b0.ins_d = 16'h555;
      tick();
      expect_v(0, 0, 31); expect_v(0, 3, 9);
      b0.ins_d = 16'h999; b0.inv_ = 1'b0; b0.inv_addr = 5'd9;
      tick();
      b0.ins_ = 1'b1; b0.inv_ = 1'b1;
      expect_v(0, 0, 32); expect_v(0, 1, 1);
      b0.re_ = 2'b10; b0.rd[0] = 16'h999;
      expect_v(0, 5, 1); expect_v(0, 7, 9);
      tick();
      b0.re_ = '1;
      b0.ins_ = 1'b0; b0.ins_d = 16'h777; b0.inv_ = 1'b0; b0.inv_addr = 5'd0;
      tick();
      expect_v(0, 4, 1); expect_v(0, 0, 31); expect_v(0, 3, 0);
      b0.inv_addr = 5'd1;
      tick();
      b0.ins_ = 1'b1; b0.inv_ = 1'b1;
      expect_v(0, 0, 31); expect_v(0, 3, 1); expect_v(0, 4, 0);
      b0.re_ = '0; b0.rd[0] = 16'h777; b0.rd[1] = 16'h100; b0.rm = '0;
      expect_v(0, 5, 1); expect_v(0, 7, 0); expect_v(0, 8, 0);
      tick();
      b0.re_ = '1;
      b0.ins_ = 1'b0; b0.ins_d = 16'h101;
      tick();
      expect_v(0, 1, 1); expect_v(0, 0, 32);
      b0.flush_ = 1'b0;
      tick();
      b0.flush_ = 1'b1; b0.ins_ = 1'b1;
      expect_v(0, 0, 0); expect_v(0, 2, 1); expect_v(0, 4, 0); expect_v(0, 1, 0);
      b0.re_ = 2'b10; b0.rd[0] = 16'h777;
      expect_v(0, 5, 0);
      tick();
      b0.re_ = '1;
      b0.ins_ = 1'b0; b0.ins_d = 16'h300;
      repeat (3) tick();
      reset_ = 1'b0;
      b0.re_ = '0; b0.rm = '1;
      #1;
      chk(0, 0, 0); chk(0, 2, 1); chk(0, 5, 0); chk(0, 8, 0);
      tick();
      idle0();
      reset_ = 1'b1;
      tick();
      expect_v(0, 0, 0); expect_v(0, 2, 1);
      for (int i = 0; i < 5; i++) begin
         b1.ins_ = 1'b0;
         b1.ins_d = 16'(16'h10 + i);
         tick();
      end
      b1.ins_ = 1'b1;
      expect_v(1, 0, 5);
      b1.re_ = 2'b10; b1.rd[0] = 16'h14; b1.rm[0] = '0;
      b1.inv_ = 1'b0; b1.inv_addr = 5'd4;
      expect_v(1, 5, 0);
      tick();
      b1.inv_ = 1'b1;
      expect_v(1, 5, 1); expect_v(1, 7, 4); expect_v(1, 6, 0); expect_v(1, 0, 4);
      tick();
      expect_v(1, 5, 0); expect_v(1, 7, 0);
      tick();
      idle1();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
